// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional build macro DIV_SIGNED_EN selects two's-complement operands and results.
module seq_restoring_divider #(
   parameter int size = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [size-1:0] dividend,
   input  logic [size-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [size-1:0] quotient,
   output logic [size-1:0] remainder,
   output logic            div_by_zero
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int cw = $clog2(size + 1);
   localparam logic [cw-1:0]   cone = cw'(1);
   localparam logic [cw-1:0]   cinit = cw'(size);

   state_t state, state_n;

   logic [cw-1:0]   count;
   logic [size:0]   prem;
   logic [size-1:0] wq;
   logic [size-1:0] dvs;

   logic [size:0]   shifted;
   logic [size:0]   trial;
   logic [size:0]   prem_n;
   logic            qbit;
   logic [size-1:0] wq_n;
   logic            last;
   logic [size-1:0] a_mag;
   logic [size-1:0] b_mag;

`ifdef DIV_SIGNED_EN
   localparam logic [size-1:0] one = size'(1);
   logic sq;
   logic sr;
   assign a_mag = dividend[size-1] ? (~dividend + one) : dividend;
   assign b_mag = divisor[size-1]  ? (~divisor + one)  : divisor;
`else
   assign a_mag = dividend;
   assign b_mag = divisor;
`endif

   assign shifted = {prem[size-1:0], wq[size-1]};
   assign trial   = shifted - {1'b0, dvs};
   assign qbit    = ~trial[size];
   assign prem_n  = qbit ? trial : shifted;
   assign wq_n    = {wq[size-2:0], qbit};
   assign last    = (count == cone);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE, DONE: state_n = start ? RUN : IDLE;
         RUN:        state_n = last ? DONE : RUN;
         default:    state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         count       <= '0;
         prem        <= '0;
         wq          <= '0;
         dvs         <= '0;
`ifdef DIV_SIGNED_EN
         sq          <= 1'b0;
         sr          <= 1'b0;
`endif
      end else begin
         busy <= (state_n == RUN);
         done <= (state_n == DONE);
         if (state != RUN && start) begin
            wq    <= a_mag;
            dvs   <= b_mag;
            prem  <= '0;
            count <= cinit;
`ifdef DIV_SIGNED_EN
            sq    <= dividend[size-1] ^ divisor[size-1];
            sr    <= dividend[size-1];
`endif
         end else if (state == RUN) begin
            prem  <= prem_n;
            wq    <= wq_n;
            count <= count - cone;
            if (last) begin
               div_by_zero <= (dvs == '0);
`ifdef DIV_SIGNED_EN
               // divide by zero forces all ones; remainder sign fix restores the dividend
               if (dvs == '0)  quotient <= '1;
               else if (sq)    quotient <= ~wq_n + one;
               else            quotient <= wq_n;
               remainder <= sr ? (~prem_n[size-1:0] + one) : prem_n[size-1:0];
`else
               quotient    <= wq_n;
               remainder   <= prem_n[size-1:0];
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomized self-checking bench for seq_restoring_divider.
// Directed cases follow the handshake, zero-divisor, abort and overlap scenarios.
module tb_seq_restoring_divider;
   localparam int size = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [size-1:0] dividend = '0;
   logic [size-1:0] divisor = '0;
   logic            busy;
   logic            done;
   logic [size-1:0] quotient;
   logic [size-1:0] remainder;
   logic            div_by_zero;

   int npass = 0;
   int ntot = 0;

   seq_restoring_divider #(.size(size)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntot++;
      if (got === exp) npass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic void model(input logic [size-1:0] a, input logic [size-1:0] b,
                                 output logic [size-1:0] q, output logic [size-1:0] r,
                                 output logic z);
`ifdef DIV_SIGNED_EN
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
`endif
      z = (b == 0);
      if (z) begin
         q = '1;
         r = a;
      end else begin
`ifdef DIV_SIGNED_EN
         q = size'(sa / sb);
         r = size'(sa % sb);
`else
         q = a / b;
         r = a % b;
`endif
      end
   endfunction

   task automatic issue(input logic [size-1:0] a, input logic [size-1:0] b);
      start = 1'b1;
      dividend = a;
      divisor = b;
   endtask

   task automatic wait_done(output int lat, output int bc);
      lat = 0;
      bc = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (busy) bc++;
      end while (!done && lat < 20);
   endtask

   task automatic run_chk(input string tag, input logic [size-1:0] a, input logic [size-1:0] b,
                          input logic [size-1:0] eq, input logic [size-1:0] er, input logic ez);
      int lat, bc;
      issue(a, b);
      wait_done(lat, bc);
      chk({tag, ".done"}, done, 1'b1);
      chk({tag, ".lat"}, lat, size + 1);
      chk({tag, ".busy"}, bc, size);
      chk({tag, ".q"}, quotient, eq);
      chk({tag, ".r"}, remainder, er);
      chk({tag, ".dbz"}, div_by_zero, ez);
   endtask

   task automatic run_model(input string tag, input logic [size-1:0] a, input logic [size-1:0] b);
      logic [size-1:0] q, r;
      logic z;
      model(a, b, q, r, z);
      run_chk(tag, a, b, q, r, z);
   endtask

   initial begin
      logic [size-1:0] eq, er, hq;
      logic ez;
      int t, ndone, tdone;
      logic [size-1:0] dq, dr;

      #12;
      chk("rst.busy", busy, 1'b0);
      chk("rst.done", done, 1'b0);
      chk("rst.q", quotient, 0);
      chk("rst.r", remainder, 0);
      chk("rst.dbz", div_by_zero, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

`ifndef DIV_SIGNED_EN
      run_chk("d13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
      @(negedge clk);
      chk("pulse", done, 1'b0);
      chk("hold.q", quotient, 4'd4);
      run_chk("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
      run_chk("b2b3_9", 4'd3, 4'd9, 4'd0, 4'd3, 1'b0);
      @(negedge clk);
      run_chk("d7_0", 4'd7, 4'd0, 4'hF, 4'd7, 1'b1);
      run_chk("d6_3", 4'd6, 4'd3, 4'd2, 4'd0, 1'b0);
      @(negedge clk);
`else
      run_chk("s-7_2", 4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0);
      run_chk("s-8_-1", 4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0);
      run_chk("s-3_0", 4'b1101, 4'b0000, 4'b1111, 4'b1101, 1'b1);
      @(negedge clk);
`endif

      // start pulsed mid-run must be ignored
      model(4'd12, 4'd5, eq, er, ez);
      issue(4'd12, 4'd5);
      t = 0;
      ndone = 0;
      tdone = 0;
      dq = '0;
      dr = '0;
      repeat (15) begin
         @(negedge clk);
         t++;
         start = (t == 2);
         if (t == 2) begin
            dividend = 4'd9;
            divisor = 4'd2;
         end
         if (done) begin
            ndone++;
            tdone = t;
            dq = quotient;
            dr = remainder;
         end
      end
      start = 1'b0;
      chk("ovl.ndone", ndone, 1);
      chk("ovl.lat", tdone, size + 1);
      chk("ovl.q", dq, eq);
      chk("ovl.r", dr, er);

      // asynchronous abort in the middle of a run
      issue(4'd14, 4'd3);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort.busy_pre", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("abort.busy", busy, 1'b0);
      chk("abort.q", quotient, 0);
      chk("abort.r", remainder, 0);
      chk("abort.dbz", div_by_zero, 1'b0);
      chk("abort.done", done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort.nodone", ndone, 0);
      run_model("fresh14_3", 4'd14, 4'd3);

      for (int i = 0; i < 40; i++) begin
         logic [size-1:0] a, b;
         a = size'($urandom);
         b = ($urandom_range(0, 7) == 0) ? '0 : size'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            @(negedge clk);
            chk("rnd.idle", done, 1'b0);
         end
         run_model($sformatf("rnd%0d", i), a, b);
      end
      hq = quotient;
      repeat (3) @(negedge clk);
      chk("rnd.hold", quotient, hq);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
